// File: rtl/rr_job_scheduler.sv
// Round-robin job scheduler sharing one start/done worker among N_REQ clients.
// Optional watchdog on the WAIT state is built when WATCHDOG_EN is defined.
module rr_job_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] ack,
    output logic             worker_start,
    input  logic             worker_done,
    output logic             busy,
    output logic             timeout_err,
    output logic [1:0]       state_out
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    generate
        if (N_REQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
            $error("rr_job_scheduler: need N_REQ >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;

`ifdef WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               to_q, to_d;
`endif

    // Rotating priority scan: the client just served gets lowest priority.
    logic               found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    int                 idx;

    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(ptr_q) + k) % N_REQ;
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(N_REQ - 1);
            win_q   <= '0;
`ifdef WATCHDOG_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
`ifdef WATCHDOG_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
`ifdef WATCHDOG_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (found) begin
                    grant_d[win_idx] = 1'b1;
                    win_d            = win_idx;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef WATCHDOG_EN
                cnt_d   = '0;
                to_d    = 1'b0;
`endif
            end
            S_WAIT: begin
`ifdef WATCHDOG_EN
                cnt_d = cnt_q + CNT_W'(1);
                if (worker_done) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                end
`else
                if (worker_done) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                ptr_d   = win_q;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant        = grant_q;
        ack          = '0;
        worker_start = 1'b0;
        busy         = (state_q != S_IDLE);
        timeout_err  = 1'b0;
        state_out    = state_q;
        unique case (state_q)
            S_IDLE:  ;
            S_ISSUE: worker_start = 1'b1;
            S_WAIT:  ;
            S_DONE: begin
                ack = grant_q;
`ifdef WATCHDOG_EN
                timeout_err = to_q;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rr_job_scheduler.sv
// Directed bench for rr_job_scheduler: vector table plus multi-cycle corner cases.
// Build with WATCHDOG_EN defined to exercise the watchdog path.
module tb_rr_job_scheduler;

    localparam int TO = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       worker_start;
    logic       worker_done;
    logic       busy;
    logic       timeout_err;
    logic [1:0] state_out;

    int errors = 0;
    int checks = 0;

    rr_job_scheduler #(
        .N_REQ   (4),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .grant        (grant),
        .ack          (ack),
        .worker_start (worker_start),
        .worker_done  (worker_done),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [1:0] st;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       start;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic [3:0] q, logic d,
                                logic [1:0] s, logic [3:0] g,
                                logic [3:0] a, logic st);
        vec_t v;
        v.rst   = r;
        v.req   = q;
        v.done  = d;
        v.st    = s;
        v.gnt   = g;
        v.ack   = a;
        v.start = st;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int starts;
        int w4;
        reset       = 1'b1;
        req         = 4'b0000;
        worker_done = 1'b0;

        // rst, req, done -> state, grant, ack, start (after the edge)
        // single client 0, done one cycle after start
        tv.push_back(mk(1, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0001, 0, 2'b01, 4'b0001, 4'b0000, 1));
        tv.push_back(mk(0, 4'b0001, 0, 2'b10, 4'b0001, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0001, 1, 2'b11, 4'b0001, 4'b0001, 0));
        tv.push_back(mk(0, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0000, 1, 2'b00, 4'b0000, 4'b0000, 0));
        // all four requesting; done also high in IDLE/ISSUE where it is ignored
        tv.push_back(mk(1, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 1, 2'b01, 4'b0001, 4'b0000, 1));
        tv.push_back(mk(0, 4'b1111, 1, 2'b10, 4'b0001, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 1, 2'b11, 4'b0001, 4'b0001, 0));
        tv.push_back(mk(0, 4'b1111, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 0, 2'b01, 4'b0010, 4'b0000, 1));
        tv.push_back(mk(0, 4'b1111, 1, 2'b10, 4'b0010, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 1, 2'b11, 4'b0010, 4'b0010, 0));
        tv.push_back(mk(0, 4'b1111, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 0, 2'b01, 4'b0100, 4'b0000, 1));
        tv.push_back(mk(0, 4'b1111, 1, 2'b10, 4'b0100, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 1, 2'b11, 4'b0100, 4'b0100, 0));
        tv.push_back(mk(0, 4'b1111, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 0, 2'b01, 4'b1000, 4'b0000, 1));
        tv.push_back(mk(0, 4'b1111, 1, 2'b10, 4'b1000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 1, 2'b11, 4'b1000, 4'b1000, 0));
        tv.push_back(mk(0, 4'b1111, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 0, 2'b01, 4'b0001, 4'b0000, 1));
        tv.push_back(mk(0, 4'b1111, 1, 2'b10, 4'b0001, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 1, 2'b11, 4'b0001, 4'b0001, 0));
        tv.push_back(mk(0, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0));
        // clients 0 and 2 alternate
        tv.push_back(mk(1, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0101, 0, 2'b01, 4'b0001, 4'b0000, 1));
        tv.push_back(mk(0, 4'b0101, 0, 2'b10, 4'b0001, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0101, 1, 2'b11, 4'b0001, 4'b0001, 0));
        tv.push_back(mk(0, 4'b0101, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0101, 0, 2'b01, 4'b0100, 4'b0000, 1));
        tv.push_back(mk(0, 4'b0101, 0, 2'b10, 4'b0100, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0101, 1, 2'b11, 4'b0100, 4'b0100, 0));
        tv.push_back(mk(0, 4'b0101, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0101, 0, 2'b01, 4'b0001, 4'b0000, 1));
        tv.push_back(mk(0, 4'b0101, 0, 2'b10, 4'b0001, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0101, 1, 2'b11, 4'b0001, 4'b0001, 0));
        tv.push_back(mk(0, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0));
        // client 1 drops req mid-job, then re-requests alone; others ignored mid-job
        tv.push_back(mk(1, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0010, 0, 2'b01, 4'b0010, 4'b0000, 1));
        tv.push_back(mk(0, 4'b0000, 0, 2'b10, 4'b0010, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0000, 1, 2'b11, 4'b0010, 4'b0010, 0));
        tv.push_back(mk(0, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0));
        tv.push_back(mk(0, 4'b0010, 0, 2'b01, 4'b0010, 4'b0000, 1));
        tv.push_back(mk(0, 4'b1111, 0, 2'b10, 4'b0010, 4'b0000, 0));
        tv.push_back(mk(0, 4'b1111, 1, 2'b11, 4'b0010, 4'b0010, 0));
        tv.push_back(mk(0, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0));

        #2;
        for (int i = 0; i < tv.size(); i++) begin
            reset       = tv[i].rst;
            req         = tv[i].req;
            worker_done = tv[i].done;
            cyc();
            chk($sformatf("v%0d state", i), 32'(state_out), 32'(tv[i].st));
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(tv[i].gnt));
            chk($sformatf("v%0d ack", i), 32'(ack), 32'(tv[i].ack));
            chk($sformatf("v%0d start", i), 32'(worker_start), 32'(tv[i].start));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].st != 2'b00));
            chk($sformatf("v%0d tmo", i), 32'(timeout_err), 32'd0);
        end

        // done withheld: WAIT holds, one start pulse only
`ifdef WATCHDOG_EN
        w4 = TO - 1;
`else
        w4 = 10;
`endif
        reset = 1'b1; req = 4'b0000; worker_done = 1'b0;
        cyc();
        reset = 1'b0; req = 4'b0001;
        cyc();
        starts = int'(worker_start);
        cyc();
        for (int i = 0; i < w4; i++) begin
            chk("hold state", 32'(state_out), 32'd2);
            chk("hold grant", 32'(grant), 32'd1);
            chk("hold busy", 32'(busy), 32'd1);
            starts += int'(worker_start);
            cyc();
        end
        worker_done = 1'b1;
        cyc();
        worker_done = 1'b0;
        req = 4'b0000;
        chk("hold done state", 32'(state_out), 32'd3);
        chk("hold ack", 32'(ack), 32'd1);
        chk("hold tmo", 32'(timeout_err), 32'd0);
        chk("start pulses", 32'(starts), 32'd1);
        cyc();
        chk("hold idle", 32'(state_out), 32'd0);

        // async reset in the middle of WAIT
        reset = 1'b1;
        cyc();
        reset = 1'b0; req = 4'b0001;
        cyc();
        cyc();
        cyc();
        chk("pre-rst state", 32'(state_out), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("async state", 32'(state_out), 32'd0);
        chk("async grant", 32'(grant), 32'd0);
        chk("async ack", 32'(ack), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        cyc();
        chk("rst held ack", 32'(ack), 32'd0);
        reset = 1'b0; req = 4'b0010;
        cyc();
        chk("post-rst grant", 32'(grant), 32'd2);
        chk("post-rst start", 32'(worker_start), 32'd1);
        req = 4'b0000;
        cyc();
        worker_done = 1'b1;
        cyc();
        worker_done = 1'b0;
        chk("post-rst ack", 32'(ack), 32'd2);
        cyc();

        // long stall: watchdog expiry or unbounded wait
        reset = 1'b1;
        cyc();
        reset = 1'b0; req = 4'b0001;
        cyc();
        req = 4'b0000;
        cyc();
`ifdef WATCHDOG_EN
        for (int i = 0; i < TO; i++) begin
            chk("wd wait", 32'(state_out), 32'd2);
            chk("wd tmo low", 32'(timeout_err), 32'd0);
            cyc();
        end
        chk("wd state", 32'(state_out), 32'd3);
        chk("wd ack", 32'(ack), 32'd1);
        chk("wd tmo", 32'(timeout_err), 32'd1);
        cyc();
        chk("wd idle", 32'(state_out), 32'd0);
        chk("wd tmo clr", 32'(timeout_err), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            chk("nowd wait", 32'(state_out), 32'd2);
            chk("nowd tmo", 32'(timeout_err), 32'd0);
            cyc();
        end
        worker_done = 1'b1;
        cyc();
        worker_done = 1'b0;
        chk("nowd ack", 32'(ack), 32'd1);
        chk("nowd tmo done", 32'(timeout_err), 32'd0);
        cyc();
        chk("nowd idle", 32'(state_out), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
